// File: rtl/inc_check_pkg.sv
// Shared types and constants for the inc_check counter-increment checker.
// The optional error counter is enabled by defining INC_CHECK_ERRCNT_EN.
package inc_check_pkg;

    localparam int CNT_W   = 16;
    localparam int ERR_W   = 16;
    localparam int MATCH_W = 4;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_e;

    // The sum is kept one bit wider so a sampled 16'hFFFF does not wrap before the modulus.
    function automatic logic [CNT_W-1:0] next_expected(
        input logic [CNT_W-1:0] cnt,
        input logic             en,
        input logic [CNT_W:0]   modulus
    );
        logic [CNT_W:0] sum;
        logic [CNT_W:0] rem;
        sum = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        rem = sum % modulus;
        if (en) begin
            return rem[CNT_W-1:0];
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/inc_check_errcnt.sv
// Saturating error-pulse counter for inc_check; cleared only by reset.
// Present only in builds that define INC_CHECK_ERRCNT_EN.
module inc_check_errcnt
    import inc_check_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [ERR_W-1:0] err_count
);

    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;

    // Next count: step on each pulse, hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {ERR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;

endmodule

// File: rtl/inc_check.sv
// Checks that an external modulo-n counter steps by one per enabled cycle.
// Define INC_CHECK_ERRCNT_EN to include the saturating err_count register.
module inc_check
    import inc_check_pkg::*;
#(
    parameter int n    = 8,
    parameter int LOCK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] count,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [CNT_W:0]   MOD    = (CNT_W+1)'(n);
    localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;

    logic [CNT_W-1:0]   exp_s;
    logic               match_s;

    assign exp_s   = next_expected(cnt_q, en_q, MOD);
    assign match_s = ({1'b0, count} < MOD) && (count == exp_s);

    // State and sample registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ACQUIRE;
            cnt_q    <= {CNT_W{1'b0}};
            en_q     <= 1'b0;
            match_q  <= {MATCH_W{1'b0}};
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

    // Next-state: clear overrides everything, FAULT is sticky otherwise.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACQUIRE;
        end else begin
            case (state_q)
                ACQUIRE: state_d = TRACK;
                TRACK: begin
                    if (match_s) begin
                        state_d = TRACK;
                    end else begin
                        state_d = FAULT;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // Outputs and match streak; the samples are taken every cycle regardless of state.
    always_comb begin
        cnt_d   = count;
        en_d    = enable;
        match_d = {MATCH_W{1'b0}};
        if (clear) begin
            match_d = {MATCH_W{1'b0}};
        end else begin
            case (state_q)
                TRACK: begin
                    if (match_s && (match_q == LOCK_V)) begin
                        match_d = match_q;
                    end else if (match_s) begin
                        match_d = match_q + {{(MATCH_W-1){1'b0}}, 1'b1};
                    end else begin
                        match_d = {MATCH_W{1'b0}};
                    end
                end
                default: match_d = {MATCH_W{1'b0}};
            endcase
        end
        locked_d = (state_d == TRACK) && (match_d == LOCK_V);
        error_d  = !clear && (state_q == TRACK) && !match_s;
    end

    assign locked = locked_q;
    assign error  = error_q;

`ifdef INC_CHECK_ERRCNT_EN
    inc_check_errcnt u_errcnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (error_d),
        .err_count (err_count)
    );
`else
    assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: doc/inc_check.md
INC_CHECK -- requirements
Module: inc_check

Interface
REQ-001 Parameter: n, default 8, modulus of the observed counter; legal range 2..65536.
REQ-002 Parameter: LOCK, default 4, consecutive matching samples required before locked asserts; legal range 1..15.
REQ-003 Port: clock  in  1  single clock; all state is updated on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: enable  in  1  the same enable that drives the observed counter.
REQ-006 Port: count  in  16  counter output being checked.
REQ-007 Port: clear  in  1  synchronous resynchronise; drops lock and reacquires.
REQ-008 Port: locked  out  1  checker is tracking and has seen LOCK consecutive matches.
REQ-009 Port: error  out  1  one-cycle pulse on a detected mismatch.
REQ-010 Port: err_count  out  16  saturating total of error pulses.

Function
REQ-011 The block SHALL sample count and enable on every posedge into cnt_q and en_q.
REQ-012 The expected value SHALL be en_q ? (cnt_q+1) mod n : cnt_q; the sum SHALL be formed in 17 bits, so no wrap occurs at 16'hFFFF.
REQ-013 A match SHALL require count == expected; any count >= n SHALL be a mismatch.
REQ-014 The FSM SHALL have exactly three states: ACQUIRE, TRACK and FAULT.
REQ-015 ACQUIRE SHALL capture cnt_q/en_q without comparing, clear the match counter, and go to TRACK on the next cycle.
REQ-016 In TRACK, a match SHALL increment the match counter, saturating at LOCK; locked SHALL be 1 while the match counter equals LOCK.
REQ-017 In TRACK, a mismatch SHALL pulse error for one cycle, clear the match counter, drop locked in the same cycle as the pulse, and go to FAULT.
REQ-018 In FAULT, locked SHALL be 0 and error SHALL be 0, with no further comparison.
REQ-019 FAULT SHALL be exited only via clear or reset.
REQ-020 clear=1 in any state SHALL force ACQUIRE next cycle and locked=0.
REQ-021 If clear=1 and a mismatch occur in the same cycle, clear SHALL win: no error pulse and no err_count increment.
REQ-022 Latency: error SHALL assert on the posedge after the first bad count value is sampled, i.e. one cycle after the counter's faulty update.
REQ-023 Wrap: with en_q=1 and cnt_q=n-1, the expected value SHALL be 0.
REQ-024 Enable low: with en_q=0, count SHALL be expected unchanged.

Reset
REQ-025 While reset=0, the state SHALL be ACQUIRE, and cnt_q, en_q, the match counter, locked, error and err_count SHALL all be 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard all history.
REQ-027 After reset deasserts, the first posedge SHALL behave as ACQUIRE.

Configuration
REQ-028 Macro INC_CHECK_ERRCNT_EN defined: err_count SHALL increment on each error pulse and saturate at 16'hFFFF; clear SHALL NOT reset it, only reset SHALL.
REQ-029 Macro INC_CHECK_ERRCNT_EN undefined: err_count SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-030 Package inc_check_pkg SHALL hold the state enum (ACQUIRE/TRACK/FAULT), the count width constant (16) and the err_count width constant (16).
REQ-031 The saturating error counter SHALL be the single sub-module inc_check_errcnt, instantiated only under INC_CHECK_ERRCNT_EN.

Verification
REQ-032 n=8, enable=1, counter-model count 0,1,...,7,0,1 -> locked=1 from the 5th posedge after reset release; error is never asserted.
REQ-033 Locked, enable=0 for 3 cycles with count held at 5 -> locked stays 1, no error.
REQ-034 Locked, count injected 3->6 (expected 4) -> error pulses once, locked=0, state FAULT, err_count=1; further bad values give no more pulses.
REQ-035 In FAULT, clear=1 for one cycle with a good stream following -> ACQUIRE then TRACK, locked=1 after LOCK matches, err_count remains 1.
REQ-036 count=9 with n=8 -> mismatch and error pulse; a mismatch in the same cycle as clear=1 -> no error pulse.
REQ-037 reset pulled low mid-TRACK with err_count=3 -> locked, error and err_count are 0 immediately, without waiting for a clock edge.
